// File: rtl/seq_alu.sv
// Registered MIPS execution unit: single-cycle ALU ops plus iterative mul/div into HI/LO.
// Define SEQ_ALU_DIV_EN to build the restoring divider (codes 1A/1B); otherwise those codes act as NOP.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  // state  | meaning
  // IDLE   | accepts start; single-cycle ops complete here
  // ITER   | one mul/div step per cycle, cnt counts WIDTH-1 down to 0
  // FIX    | apply signs, write hi/lo/alu_out/zero, pulse done
  localparam logic [1:0] S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2;

  localparam logic [4:0] OP_ADD  = 5'h01, OP_SUB  = 5'h02, OP_AND  = 5'h03, OP_OR   = 5'h04,
                         OP_XOR  = 5'h05, OP_NOR  = 5'h06, OP_BGTZ = 5'h07, OP_LUI  = 5'h08,
                         OP_SLL  = 5'h09, OP_JUMP = 5'h10, OP_BNE  = 5'h11, OP_BEQ  = 5'h12,
                         OP_SLLV = 5'h13, OP_SRL  = 5'h14, OP_SRLV = 5'h15, OP_BLTZ = 5'h16,
                         OP_BGEZ = 5'h17, OP_MULT = 5'h18, OP_MULTU = 5'h19, OP_DIV = 5'h1A,
                         OP_DIVU = 5'h1B, OP_MFHI = 5'h1C, OP_MFLO = 5'h1D;

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc, sh, opnd;
  logic             neg_q;

  logic             is_mul, is_dv, op_signed, is_br, br_t, res_z;
  logic [WIDTH-1:0] res, mag_a_in, mag_b_in, new_hi, new_lo;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign is_mul    = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
`ifdef SEQ_ALU_DIV_EN
  assign is_dv     = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
`else
  assign is_dv     = 1'b0;
`endif
  assign op_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign mag_a_in  = (op_signed && alu_a[WIDTH-1]) ? -alu_a : alu_a;
  assign mag_b_in  = (op_signed && alu_b[WIDTH-1]) ? -alu_b : alu_b;

  always_comb begin
    res   = '0;
    is_br = 1'b0;
    br_t  = 1'b0;
    case (alu_op)
      OP_ADD:  res = alu_a + alu_b;
      OP_SUB:  res = alu_a - alu_b;
      OP_AND:  res = alu_a & alu_b;
      OP_OR:   res = alu_a | alu_b;
      OP_XOR:  res = alu_a ^ alu_b;
      OP_NOR:  res = ~(alu_a | alu_b);
      OP_LUI: begin
        res       = {WIDTH{alu_b[15]}};
        res[31:0] = {alu_b[15:0], 16'h0000};
      end
      OP_SLL:  res = alu_a << alu_b[10:6];
      OP_SLLV: res = alu_b << alu_a[SHW-1:0];
      OP_SRL:  res = alu_a >> alu_b[10:6];
      OP_SRLV: res = alu_b >> alu_a[SHW-1:0];
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      OP_BGTZ: begin is_br = 1'b1; br_t = !alu_a[WIDTH-1] && (alu_a != '0); end
      OP_JUMP: begin is_br = 1'b1; br_t = 1'b1; end
      OP_BNE:  begin is_br = 1'b1; br_t = (alu_a != alu_b); end
      OP_BEQ:  begin is_br = 1'b1; br_t = (alu_a == alu_b); end
      OP_BLTZ: begin is_br = 1'b1; br_t = alu_a[WIDTH-1]; end
      OP_BGEZ: begin is_br = 1'b1; br_t = !alu_a[WIDTH-1]; end
      default: ;
    endcase
    // undefined codes fall through with res=0, hence zero=1
    res_z = is_br ? br_t : (res == '0);
  end

  // shift-add step: acc holds the running high half, sh the multiplier/low half
  assign mul_sum = {1'b0, acc} + {1'b0, (sh[0] ? opnd : {WIDTH{1'b0}})};

`ifdef SEQ_ALU_DIV_EN
  logic             is_div, neg_r, b_zero, div_ge;
  logic [WIDTH-1:0] a_raw, div_diff;
  logic [WIDTH:0]   div_sh;

  assign div_sh   = {acc, sh[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, opnd});
  assign div_diff = div_sh[WIDTH-1:0] - opnd;
`endif

  always_comb begin
    prod   = {acc, sh};
    prod_s = neg_q ? -prod : prod;
    new_hi = prod_s[2*WIDTH-1:WIDTH];
    new_lo = prod_s[WIDTH-1:0];
`ifdef SEQ_ALU_DIV_EN
    if (is_div) begin
      new_lo = b_zero ? {WIDTH{1'b1}} : (neg_q ? -sh : sh);
      new_hi = b_zero ? a_raw : (neg_r ? -acc : acc);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      sh      <= '0;
      opnd    <= '0;
      neg_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_out <= '0;
      zero    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef SEQ_ALU_DIV_EN
      is_div  <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      a_raw   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (is_mul || is_dv) begin
            state <= S_ITER;
            busy  <= 1'b1;
            cnt   <= SHW'(WIDTH - 1);
            acc   <= '0;
            sh    <= is_mul ? mag_b_in : mag_a_in;
            opnd  <= is_mul ? mag_a_in : mag_b_in;
            neg_q <= op_signed && (alu_a[WIDTH-1] ^ alu_b[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
            is_div <= is_dv;
            neg_r  <= op_signed && alu_a[WIDTH-1];
            b_zero <= (alu_b == '0);
            a_raw  <= alu_a;
`endif
          end else begin
            alu_out <= res;
            zero    <= res_z;
            done    <= 1'b1;
          end
        end
        S_ITER: begin
`ifdef SEQ_ALU_DIV_EN
          if (is_div) begin
            acc <= div_ge ? div_diff : div_sh[WIDTH-1:0];
            sh  <= {sh[WIDTH-2:0], div_ge};
          end else
`endif
          begin
            acc <= mul_sum[WIDTH:1];
            sh  <= {mul_sum[0], sh[WIDTH-1:1]};
          end
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          hi      <= new_hi;
          lo      <= new_lo;
          alu_out <= new_lo;
          zero    <= (new_lo == '0);
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: vector table and scoreboard on a 32-bit unit, spot checks on a 64-bit unit.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        busy, done, zero;
  logic [31:0] alu_out, hi, lo;

  logic        s_start;
  logic [4:0]  s_op;
  logic [63:0] s_a, s_b;
  logic        s_busy, s_done, s_zero;
  logic [63:0] s_out, s_hi, s_lo;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .busy(busy), .done(done), .alu_out(alu_out), .zero(zero), .hi(hi), .lo(lo));

  seq_alu #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(s_start), .alu_op(s_op), .alu_a(s_a), .alu_b(s_b),
    .busy(s_busy), .done(s_done), .alu_out(s_out), .zero(s_zero), .hi(s_hi), .lo(s_lo));

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, out;
    logic        z;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        z;
    logic [31:0] hi, lo;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got alu_out=%h expected no done", alu_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_out"}, 64'(alu_out), 64'(mon_e.out));
        chk({mon_e.name, "_zero"}, 64'(zero), 64'(mon_e.z));
        chk({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
        chk({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
        chk({mon_e.name, "_busy"}, 64'(busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
  endtask

  task automatic push(input string nm, input logic [31:0] out, input logic z);
    exp_q.push_back('{nm, out, z, m_hi, m_lo});
  endtask

  task automatic push_md(input string nm, input logic [31:0] h, input logic [31:0] l);
    m_hi = h;
    m_lo = l;
    exp_q.push_back('{nm, l, (l == 32'h0), h, l});
  endtask

  task automatic drain();
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run64(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    s_start = 1'b1;
    s_op    = op;
    s_a     = a;
    s_b     = b;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb, q, r;
    logic [63:0] p;
    longint sa, sb;

    rst = 1'b1; start = 1'b0; alu_op = '0; alu_a = '0; alu_b = '0;
    s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0;

    vecs.push_back('{5'h01, 32'd5, 32'd7, 32'd12, 1'b0});
    vecs.push_back('{5'h02, 32'd7, 32'd7, 32'd0, 1'b1});
    vecs.push_back('{5'h02, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{5'h03, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
    vecs.push_back('{5'h04, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0});
    vecs.push_back('{5'h05, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0});
    vecs.push_back('{5'h06, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0});
    vecs.push_back('{5'h00, 32'd5, 32'd6, 32'd0, 1'b1});
    vecs.push_back('{5'h08, 32'd0, 32'h00008000, 32'h80000000, 1'b0});
    vecs.push_back('{5'h09, 32'd1, 32'h00000100, 32'h00000010, 1'b0});
    vecs.push_back('{5'h13, 32'd4, 32'd3, 32'h00000030, 1'b0});
    vecs.push_back('{5'h14, 32'h80000000, 32'h000007C0, 32'd1, 1'b0});
    vecs.push_back('{5'h15, 32'd4, 32'h80000000, 32'h08000000, 1'b0});
    vecs.push_back('{5'h12, 32'h1234, 32'h1234, 32'd0, 1'b1});
    vecs.push_back('{5'h11, 32'h1234, 32'h1234, 32'd0, 1'b0});
    vecs.push_back('{5'h07, 32'd0, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{5'h07, 32'd5, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{5'h07, 32'h80000000, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{5'h16, 32'h80000000, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{5'h17, 32'd0, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{5'h17, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{5'h10, 32'd0, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{5'h0A, 32'd1, 32'd2, 32'd0, 1'b1});
    vecs.push_back('{5'h1F, 32'd1, 32'd2, 32'd0, 1'b1});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(alu_out), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    // back-to-back single-cycle ops, one start per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      push($sformatf("vec%0d", i), vecs[i].out, vecs[i].z);
      chk("single_busy", 64'(busy), 64'd0);
    end
    drain();

    issue(5'h18, 32'hFFFFFFFF, 32'd3);
    push_md("mult", 32'hFFFFFFFF, 32'hFFFFFFFD);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mult_busy_cycles", 64'(n), 64'd33);
    chk("mult_done_at_fall", 64'(done), 64'd1);
    drain();

    issue(5'h19, 32'hFFFFFFFF, 32'd3);
    push_md("multu", 32'h00000002, 32'hFFFFFFFD);
    drain();
    issue(5'h1C, 32'd0, 32'd0);
    push("mfhi", 32'h2, 1'b0);
    issue(5'h1D, 32'd0, 32'd0);
    push("mflo", 32'hFFFFFFFD, 1'b0);
    drain();

`ifdef SEQ_ALU_DIV_EN
    issue(5'h1B, 32'd100, 32'd7);
    push_md("divu", 32'd2, 32'd14);
    drain();
    issue(5'h1A, 32'hFFFFFFF9, 32'd2);
    push_md("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    drain();
    issue(5'h1A, 32'd9, 32'd0);
    push_md("div_by0", 32'd9, 32'hFFFFFFFF);
    drain();
    issue(5'h1A, 32'h80000000, 32'hFFFFFFFF);
    push_md("div_ovf", 32'd0, 32'h80000000);
    drain();
`else
    issue(5'h1A, 32'd9, 32'd0);
    push("div_nomacro", 32'd0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("div_nomacro_busy", 64'(busy), 64'd0);
    drain();
`endif

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) begin
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        p = 64'(sa * sb);
        issue(5'h18, ra, rb);
        push_md($sformatf("rmult%0d", i), p[63:32], p[31:0]);
      end else if (i % 4 == 1) begin
        p = {32'h0, ra} * {32'h0, rb};
        issue(5'h19, ra, rb);
        push_md($sformatf("rmultu%0d", i), p[63:32], p[31:0]);
`ifdef SEQ_ALU_DIV_EN
      end else if (i % 4 == 2) begin
        rb = rb >> (i % 20);
        if (rb == 32'h0) rb = 32'd3;
        q = ra / rb;
        r = ra % rb;
        issue(5'h1B, ra, rb);
        push_md($sformatf("rdivu%0d", i), r, q);
      end else begin
        rb = rb >> 16;
        if (rb == 32'h0) rb = 32'd5;
        if (i == 7) rb = -rb;
        q = $signed(ra) / $signed(rb);
        r = $signed(ra) % $signed(rb);
        issue(5'h1A, ra, rb);
        push_md($sformatf("rdiv%0d", i), r, q);
`else
      end else begin
        issue(5'h01, ra, rb);
        push($sformatf("radd%0d", i), ra + rb, (ra + rb) == 32'h0);
`endif
      end
      drain();
    end

    // start pulsed mid-multiply must be dropped
    issue(5'h19, 32'd5, 32'd6);
    push_md("multu_ign", 32'd0, 32'd30);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; alu_op = 5'h01; alu_a = 32'd1; alu_b = 32'd1;
    drain();
    repeat (5) @(negedge clk);

    // reset mid-operation discards the multiply
    issue(5'h18, 32'd7, 32'd9);
    push_md("mult_rst", 32'd0, 32'd63);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_out", 64'(alu_out), 64'd0);
    repeat (40) @(negedge clk);

    // start held across the edge where busy falls: accepted one edge later
    issue(5'h19, 32'd4, 32'd4);
    push_md("multu_fall", 32'd0, 32'd16);
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    chk("fall_busy_before", 64'(busy), 64'd1);
    start = 1'b1; alu_op = 5'h01; alu_a = 32'd2; alu_b = 32'd3;
    push("add_after_fall", 32'd5, 1'b0);
    @(negedge clk);
    chk("fall_busy_after", 64'(busy), 64'd0);
    drain();
    repeat (3) @(negedge clk);

    run64(5'h13, 64'd40, 64'd1);
    chk("w64_sllv_done", 64'(s_done), 64'd1);
    chk("w64_sllv", s_out, 64'h0000010000000000);
    run64(5'h08, 64'd0, 64'h8000);
    chk("w64_lui", s_out, 64'hFFFFFFFF80000000);
    chk("w64_lui_zero", 64'(s_zero), 64'd0);
    run64(5'h18, 64'hFFFFFFFFFFFFFFFF, 64'd3);
    n = 1;
    while (s_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("w64_mult_cycles", 64'(n), 64'd66);
    chk("w64_mult_done", 64'(s_done), 64'd1);
    chk("w64_mult_hi", s_hi, 64'hFFFFFFFFFFFFFFFF);
    chk("w64_mult_lo", s_lo, 64'hFFFFFFFFFFFFFFFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered execution unit for the MIPS datapath that replaces the purely combinational ALU. It keeps the existing 5-bit operation encoding and branch-condition `zero` semantics, generalises the datapath to `WIDTH` bits, and adds iterative multiply/divide into internal HI/LO registers behind a start/busy/done handshake. It sits in the EX stage; the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32: datapath width; legal values 32 or 64.
- `SHW`, `$clog2(WIDTH)`: shift-amount width for variable shifts (derived, not overridden).
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  operation request; sampled on a rising edge only when `busy`=0.
- `alu_op`  in  5  operation code, sampled with `start`.
- `alu_a`  in  WIDTH  operand A (signed view for signed ops), sampled with `start`.
- `alu_b`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse: `alu_out`/`zero` (and HI/LO for mul/div) valid.
- `alu_out`  out  WIDTH  registered result.
- `zero`  out  1  registered branch-taken / zero flag.
- `hi`, `lo`  out  WIDTH each  current HI/LO register contents.

## Operation
- Single-cycle codes (result computed from sampled operands, `zero`=(result==0) unless noted): 00 NOP→0; 01 ADD; 02 SUB (wrap, no overflow trap); 03 AND; 04 OR; 05 XOR; 06 NOR; 08 LUI→`alu_b[15:0]`<<16, bits above 31 copy `alu_b[15]`; 09 SLL `alu_a`<<`alu_b[10:6]`; 13 SLLV `alu_b`<<`alu_a[SHW-1:0]`; 14 SRL `alu_a`>>`alu_b[10:6]` logical; 15 SRLV `alu_b`>>`alu_a[SHW-1:0]` logical; 1C MFHI→`hi`; 1D MFLO→`lo`.
- Branch codes (result 0, `zero` = condition): 07 BGTZ a>0 signed; 10 JUMP→1; 11 BNE a≠b; 12 BEQ a==b; 16 BLTZ a<0; 17 BGEZ a≥0.
- Multi-cycle codes: 18 MULT signed, 19 MULTU → {hi,lo}=2·WIDTH-bit product; 1A DIV signed, 1B DIVU → lo=quotient, hi=remainder (remainder takes dividend sign). `alu_out`=new lo at `done`; `zero`=(new lo==0).
- Mul: radix-2 shift-add on operand magnitudes; div: restoring on magnitudes; signs fixed in final cycle.
- Divide by zero: lo=all ones, hi=`alu_a`, full latency. DIV of most-negative by −1: lo=most-negative, hi=0.
- Undefined codes: behave as NOP (result 0, `zero`=1, single cycle).
- FSM: IDLE → (start & mul/div) → ITER (counter WIDTH−1 down to 0) → FIX → IDLE. Single-cycle ops never leave IDLE.
- `start` while `busy`=1 is ignored (no queueing). HI/LO change only at FIX or reset.

## Timing
- Reset values: `busy`=0, `done`=0, `alu_out`=0, `zero`=0, `hi`=0, `lo`=0, FSM=IDLE, counter=0.
- Single-cycle op sampled at edge k: `alu_out`/`zero` updated and `done`=1 during cycle after k; `busy` stays 0. Back-to-back starts each cycle allowed.
- Mul/div sampled at edge k: `busy`=1 after edge k through edge k+WIDTH+1; ITER on edges k+1..k+WIDTH; FIX at edge k+WIDTH+1 writes hi/lo/alu_out/zero, `busy`→0, `done`=1 for that one cycle. Latency WIDTH+1 edges (33 at WIDTH=32).
- `start` at the same edge `busy` falls is not accepted; next accept is the following edge.
- `alu_out`/`zero` hold last value when `done`=0.
- `rst` mid-operation: all outputs to reset values at that edge, operation discarded, no `done`.

## Configuration
- `SEQ_ALU_DIV_EN` defined: codes 1A/1B implemented as above.
- Not defined: divider logic absent; 1A/1B treated as undefined codes (single cycle, result 0, `zero`=1, HI/LO unchanged, `busy` never asserted).

## Test plan
- WIDTH=32, ADD a=5 b=7 → next cycle `alu_out`=12, `zero`=0, `done`=1, `busy`=0; SUB a=7 b=7 → `zero`=1.
- BEQ a=b=0x1234 → `zero`=1; BNE same → `zero`=0; BGTZ a=0 → 0; BLTZ a=0x80000000 → 1.
- MULT a=−1 b=3 → `busy` 33 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFD, `done` one cycle; MULTU same operands → `hi`=0x00000002, `lo`=0xFFFFFFFD.
- DIVU 100/7 → `lo`=14, `hi`=2; DIV −7/2 → `lo`=−3, `hi`=−1; DIV 9/0 → `lo`=0xFFFFFFFF, `hi`=9 (with macro); without macro → single-cycle, HI/LO unchanged.
- Start MULT, pulse ADD `start` at cycle 5 → ignored, MULT completes unchanged; assert `rst` at cycle 10 → `busy`=0, `hi`=`lo`=0, no `done`.
- WIDTH=64, SLLV a=40 b=1 → `alu_out`=1<<40; LUI b=0x8000 → 0xFFFFFFFF80000000.
